// File: rtl/changecode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : changecode_arbiter
// Description : Round-robin sequencer that time-shares one combinational
//               changecode converter between two requesters, captures each
//               requester's result/error, pulses a per-requester done and
//               keeps a saturating count of conversions that reported error.
// Revision    : 1.0 - initial release
// ============================================================================
module changecode_arbiter #(
  parameter int BITS  = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_0,
  input  logic [BITS-1:0]  i_arg_0,
  input  logic             i_req_1,
  input  logic [BITS-1:0]  i_arg_1,
  output logic [BITS-1:0]  o_cc_argA,
  input  logic [BITS-1:0]  i_cc_result,
  input  logic             i_cc_error,
  output logic             o_done_0,
  output logic             o_done_1,
  output logic [BITS-1:0]  o_result_0,
  output logic [BITS-1:0]  o_result_1,
  output logic             o_error_0,
  output logic             o_error_1,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ptr;       // requester that wins the next tie
  logic              r_sel;       // requester owning the current conversion
  logic [BITS-1:0]   r_arg;       // operand held on the converter input
  logic [BITS-1:0]   r_result_0;
  logic [BITS-1:0]   r_result_1;
  logic              r_error_0;
  logic              r_error_1;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              w_any_req;
  logic              w_grant;
  logic              w_take;

  // Next-state and grant selection; a tie goes to the priority pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_any_req   = i_req_0 | i_req_1;
    w_grant     = 1'b0;
    if (i_req_0 && i_req_1) begin
      w_grant = r_ptr;
    end else begin
      w_grant = i_req_1;
    end
    w_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_take      = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant capture: latch the winner's operand and index, hand priority to the loser.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_arg <= '0;
      r_sel <= 1'b0;
      r_ptr <= 1'b0;
    end else if (w_take) begin
      r_arg <= w_grant ? i_arg_1 : i_arg_0;
      r_sel <= w_grant;
      r_ptr <= ~w_grant;
    end
  end

  // Result capture at the end of CONV into the owning requester only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result_0 <= '0;
      r_result_1 <= '0;
      r_error_0  <= 1'b0;
      r_error_1  <= 1'b0;
      r_err_cnt  <= '0;
    end else if (r_state == S_CONV) begin
      if (r_sel) begin
        r_result_1 <= i_cc_result;
        r_error_1  <= i_cc_error;
      end else begin
        r_result_0 <= i_cc_result;
        r_error_0  <= i_cc_error;
      end
      // Counter sticks at all-ones rather than wrapping.
      if (i_cc_error && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cc_argA  = r_arg;
  assign o_done_0   = (r_state == S_DONE) && !r_sel;
  assign o_done_1   = (r_state == S_DONE) &&  r_sel;
  assign o_result_0 = r_result_0;
  assign o_result_1 = r_result_1;
  assign o_error_0  = r_error_0;
  assign o_error_1  = r_error_1;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_changecode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_changecode_arbiter
// Description : Scoreboard bench for changecode_arbiter with an inverting
//               stub converter that flags operand 4'b1000 as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_changecode_arbiter;

  localparam int BITS  = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_0, req_1;
  logic [BITS-1:0]  arg_0, arg_1;
  logic [BITS-1:0]  cc_argA, cc_result;
  logic             cc_error;
  logic             done_0, done_1;
  logic [BITS-1:0]  result_0, result_1;
  logic             error_0, error_1;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    int               idx;
    int               cyc;
    logic [BITS-1:0]  r0;
    logic [BITS-1:0]  r1;
    logic             e0;
    logic             e1;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc    = 0;
  logic [BITS-1:0]  m_r0, m_r1;
  logic             m_e0, m_e1;
  logic [CNT_W-1:0] m_cnt;

  changecode_arbiter #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_0    (req_0),
    .i_arg_0    (arg_0),
    .i_req_1    (req_1),
    .i_arg_1    (arg_1),
    .o_cc_argA  (cc_argA),
    .i_cc_result(cc_result),
    .i_cc_error (cc_error),
    .o_done_0   (done_0),
    .o_done_1   (done_1),
    .o_result_0 (result_0),
    .o_result_1 (result_1),
    .o_error_0  (error_0),
    .o_error_1  (error_1),
    .o_busy     (busy),
    .o_err_cnt  (err_cnt)
  );

  // Stub converter.
  assign cc_result = ~cc_argA;
  assign cc_error  = (cc_argA == 4'b1000);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_r0 = '0; m_r1 = '0; m_e0 = 1'b0; m_e1 = 1'b0; m_cnt = '0;
  endtask

  // Record the expected outcome of one conversion for requester idx.
  task automatic expect_conv(input int idx, input logic [BITS-1:0] a, input int done_cyc);
    exp_t e;
    logic err;
    err = (a == 4'b1000);
    if (idx == 0) begin m_r0 = ~a; m_e0 = err; end
    else          begin m_r1 = ~a; m_e1 = err; end
    if (err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.idx = idx; e.cyc = done_cyc;
    e.r0 = m_r0; e.r1 = m_r1; e.e0 = m_e0; e.e1 = m_e1; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    {31'd0, busy},               32'd0);
    check({tag, "_done"},    {30'd0, done_1, done_0},     32'd0);
    check({tag, "_results"}, {24'd0, result_1, result_0}, 32'd0);
    check({tag, "_errors"},  {30'd0, error_1, error_0},   32'd0);
    check({tag, "_cnt"},     {24'd0, err_cnt},            32'd0);
    check({tag, "_argA"},    {28'd0, cc_argA},            32'd0);
  endtask

  // Monitor: pop and compare on every done pulse, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (done_0 || done_1) begin
      checks++;
      if (done_0 && done_1) begin
        errors++;
        $display("FAIL done_both: both done pulses high (cycle %0d)", cyc);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done_0=%0b done_1=%0b with nothing pending (cycle %0d)",
                 done_0, done_1, cyc);
      end else begin
        e = sb.pop_front();
        check("mon_idx",  {31'd0, done_1}, e.idx);
        check("mon_cyc",  cyc,             e.cyc);
        check("mon_res0", {28'd0, result_0}, {28'd0, e.r0});
        check("mon_err0", {31'd0, error_0},  {31'd0, e.e0});
        check("mon_res1", {28'd0, result_1}, {28'd0, e.r1});
        check("mon_err1", {31'd0, error_1},  {31'd0, e.e1});
        check("mon_cnt",  {24'd0, err_cnt},  {24'd0, e.cnt});
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1; req_0 = 1'b0; req_1 = 1'b0; arg_0 = '0; arg_1 = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all_zero("idle");
    end

    // Single request from requester 0.
    c = cyc; req_0 = 1'b1; arg_0 = 4'b0001;
    expect_conv(0, 4'b0001, c + 2);
    tick();
    check("single_busy_c1", {31'd0, busy}, 32'd1);
    check("single_argA", {28'd0, cc_argA}, 32'h1);
    tick();
    req_0 = 1'b0;
    tick();
    check("single_busy_c3", {31'd0, busy}, 32'd0);
    repeat (2) tick();

    // Reset so the pointer starts at 0, then a tie.
    rst = 1'b1; tick(); rst = 1'b0; model_reset();
    tick();
    c = cyc; req_0 = 1'b1; arg_0 = 4'b1001; req_1 = 1'b1; arg_1 = 4'b1101;
    expect_conv(0, 4'b1001, c + 2);   // tie, pointer 0
    expect_conv(1, 4'b1101, c + 5);   // tie again at c+3, loser now wins
    expect_conv(0, 4'b1001, c + 8);   // requester 0 alone
    repeat (5) tick();
    req_1 = 1'b0;
    repeat (3) tick();
    req_0 = 1'b0;
    repeat (2) tick();

    // Pointer now favours requester 1 on a fresh tie.
    c = cyc; req_0 = 1'b1; arg_0 = 4'b0011; req_1 = 1'b1; arg_1 = 4'b0101;
    expect_conv(1, 4'b0101, c + 2);
    expect_conv(0, 4'b0011, c + 5);
    repeat (2) tick();
    req_1 = 1'b0;
    repeat (3) tick();
    req_0 = 1'b0;
    repeat (2) tick();

    // Error path, single conversion.
    c = cyc; req_1 = 1'b1; arg_1 = 4'b1000;
    expect_conv(1, 4'b1000, c + 2);
    repeat (2) tick();
    req_1 = 1'b0;
    repeat (2) tick();
    check("err_cnt_one", {24'd0, err_cnt}, 32'd1);
    check("err_flag_1", {31'd0, error_1}, 32'd1);

    // Held error request: 260 conversions, counter must stick at 255.
    c = cyc; req_1 = 1'b1; arg_1 = 4'b1000;
    for (int k = 0; k < 260; k++) expect_conv(1, 4'b1000, c + 2 + 3 * k);
    repeat (2 + 3 * 259) tick();
    req_1 = 1'b0;
    repeat (2) tick();
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset asserted in the CONV cycle drops the conversion.
    req_0 = 1'b1; arg_0 = 4'b0010;
    tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; req_0 = 1'b0;
    tick();
    check_all_zero("midrst");
    rst = 1'b0; model_reset();
    repeat (4) tick();
    check_all_zero("postrst");

    // Next request completes normally.
    c = cyc; req_0 = 1'b1; arg_0 = 4'b0100;
    expect_conv(0, 4'b0100, c + 2);
    repeat (2) tick();
    req_0 = 1'b0;
    repeat (2) tick();

    // Held request: done every 3 cycles.
    c = cyc; req_0 = 1'b1; arg_0 = 4'b1111;
    for (int k = 0; k < 4; k++) expect_conv(0, 4'b1111, c + 2 + 3 * k);
    repeat (2 + 3 * 3) tick();
    req_0 = 1'b0;
    repeat (5) tick();

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
